// File: rtl/arrow_track_scroller.sv
// Per-player arrow track: scrolls a 26-slot code track on frame boundaries and judges button presses.
// Build macro COMBO_SCORE_EN adds the combo output and the combo score bonus.
//
// state | meaning
// OPEN  | slot0 may still be judged by a button press
// DONE  | a press has been judged; further presses ignored until the next step
`timescale 1ns/1ps
module arrow_track_scroller #(
  parameter int SLOTS           = 26,
  parameter int FRAMES_PER_STEP = 8,
  parameter int INDICATOR_HOLD  = 30
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               iVS,
  input  logic               enable,
  input  logic [2:0]         new_code,
  input  logic               new_code_valid,
  output logic               new_code_ready,
  input  logic [3:0]         btn,
  output logic [3*SLOTS-1:0] arrow_indexes,
  output logic [1:0]         good_bad,
  output logic [15:0]        score,
  output logic               step_pulse
`ifdef COMBO_SCORE_EN
  ,
  output logic [7:0]         combo
`endif
);

  localparam int          TW        = 3 * SLOTS;
  localparam logic [7:0]  STEP_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0]  HOLD_INIT = 8'(INDICATOR_HOLD);
  localparam logic [1:0]  GB_NONE   = 2'b00;
  localparam logic [1:0]  GB_GOOD   = 2'b01;
  localparam logic [1:0]  GB_BAD    = 2'b10;

  typedef enum logic {ST_OPEN, ST_DONE} judge_state_e;

  logic            vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_prev_q, vs_prev_d;
  logic            frame_tick_q, frame_tick_d;
  logic [3:0]      btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
  logic [7:0]      step_cnt_q, step_cnt_d;
  logic [7:0]      hold_q, hold_d;
  logic [TW-1:0]   track_q, track_d;
  logic [TW-1:0]   arrow_indexes_q, arrow_indexes_d;
  judge_state_e    state_q, state_d;
  logic [1:0]      good_bad_q, good_bad_d;
  logic [15:0]     score_q, score_d;
`ifdef COMBO_SCORE_EN
  logic [7:0]      combo_q, combo_d;
`endif

  logic [3:0]      press;
  logic [2:0]      slot0;
  logic [3:0]      code_onehot;
  logic [2:0]      load_code;
  logic            step, judge_open, hit_good, press_bad, miss, any_bad;
  logic [16:0]     score_inc, score_sum;

  always_comb begin
    vs_s1_d      = iVS;
    vs_s2_d      = vs_s1_q;
    vs_prev_d    = vs_s2_q;
    frame_tick_d = vs_prev_q & ~vs_s2_q;
    btn_s1_d     = btn;
    btn_s2_d     = btn_s1_q;
    btn_prev_d   = btn_s2_q;

    press = btn_s2_q & ~btn_prev_q;
    slot0 = track_q[2:0];
    step  = frame_tick_q & enable & (step_cnt_q == STEP_LAST);

    case (slot0)
      3'd1:    code_onehot = 4'b0001;
      3'd2:    code_onehot = 4'b0010;
      3'd3:    code_onehot = 4'b0100;
      3'd4:    code_onehot = 4'b1000;
      default: code_onehot = 4'b0000;
    endcase

    // press is non-zero here, so a match implies slot0 holds a real arrow
    judge_open = (state_q == ST_OPEN) && (press != 4'b0);
    hit_good   = judge_open && (press == code_onehot);
    press_bad  = judge_open && !hit_good;
    miss       = step && (slot0 != 3'd0) && !hit_good;
    any_bad    = press_bad | miss;

    load_code = (new_code_valid && new_code <= 3'd4) ? new_code : 3'd0;

    step_cnt_d = step_cnt_q;
    if (frame_tick_q && enable)
      step_cnt_d = step ? 8'd0 : step_cnt_q + 8'd1;

    track_d = track_q;
    if (step)
      track_d = {load_code, track_q[TW-1:3]};
    else if (hit_good)
      track_d[2:0] = 3'd0;
    arrow_indexes_d = track_q;

    state_d = state_q;
    if (step)
      state_d = ST_OPEN;
    else if (judge_open)
      state_d = ST_DONE;

    good_bad_d = good_bad_q;
    hold_d     = hold_q;
    if (any_bad) begin
      good_bad_d = GB_BAD;
      hold_d     = HOLD_INIT;
    end else if (hit_good) begin
      good_bad_d = GB_GOOD;
      hold_d     = HOLD_INIT;
    end else if (frame_tick_q && hold_q != 8'd0) begin
      hold_d = hold_q - 8'd1;
      if (hold_q == 8'd1)
        good_bad_d = GB_NONE;
    end

`ifdef COMBO_SCORE_EN
    score_inc = (combo_q >= 8'd9) ? 17'd2 : 17'd1;
    combo_d   = combo_q;
    if (any_bad)
      combo_d = 8'd0;
    else if (hit_good && combo_q != 8'hFF)
      combo_d = combo_q + 8'd1;
`else
    score_inc = 17'd1;
`endif
    score_sum = {1'b0, score_q} + score_inc;
    score_d   = score_q;
    if (hit_good)
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_s1_q         <= 1'b1;
      vs_s2_q         <= 1'b1;
      vs_prev_q       <= 1'b1;
      frame_tick_q    <= 1'b0;
      btn_s1_q        <= 4'b0;
      btn_s2_q        <= 4'b0;
      btn_prev_q      <= 4'b0;
      step_cnt_q      <= 8'd0;
      hold_q          <= 8'd0;
      track_q         <= '0;
      arrow_indexes_q <= '0;
      state_q         <= ST_OPEN;
      good_bad_q      <= GB_NONE;
      score_q         <= 16'd0;
`ifdef COMBO_SCORE_EN
      combo_q         <= 8'd0;
`endif
    end else begin
      vs_s1_q         <= vs_s1_d;
      vs_s2_q         <= vs_s2_d;
      vs_prev_q       <= vs_prev_d;
      frame_tick_q    <= frame_tick_d;
      btn_s1_q        <= btn_s1_d;
      btn_s2_q        <= btn_s2_d;
      btn_prev_q      <= btn_prev_d;
      step_cnt_q      <= step_cnt_d;
      hold_q          <= hold_d;
      track_q         <= track_d;
      arrow_indexes_q <= arrow_indexes_d;
      state_q         <= state_d;
      good_bad_q      <= good_bad_d;
      score_q         <= score_d;
`ifdef COMBO_SCORE_EN
      combo_q         <= combo_d;
`endif
    end
  end

  assign arrow_indexes  = arrow_indexes_q;
  assign good_bad       = good_bad_q;
  assign score          = score_q;
  assign step_pulse     = step;
  assign new_code_ready = step;
`ifdef COMBO_SCORE_EN
  assign combo          = combo_q;
`endif

endmodule

// File: tb/tb_arrow_track_scroller.sv
// Scoreboard bench for arrow_track_scroller: a frame/press-level model predicts each step and
// each good_bad change; a monitor pops and compares when the DUT shows them.
`timescale 1ns/1ps
module tb_arrow_track_scroller;
  localparam int SLOTS = 26;
  localparam int FPS   = 8;
  localparam int HOLD  = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  code = 3'd0;
  logic        code_valid = 1'b0;
  logic        ready;
  logic [3:0]  btn = 4'b0;
  logic [77:0] ai;
  logic [1:0]  gb;
  logic [15:0] score;
  logic        step_pulse;
`ifdef COMBO_SCORE_EN
  logic [7:0]  combo;
`endif

  arrow_track_scroller dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(vs), .enable(en),
    .new_code(code), .new_code_valid(code_valid), .new_code_ready(ready),
    .btn(btn), .arrow_indexes(ai), .good_bad(gb), .score(score),
    .step_pulse(step_pulse)
`ifdef COMBO_SCORE_EN
    , .combo(combo)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit in_reset = 1'b1;

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int m_track[SLOTS];
  int m_score, m_gb, m_hold, m_cnt;
  bit m_done;

  typedef struct {
    int unsigned cyc;
    logic [77:0] pre_ai, post_ai;
    int pre_score, post_score, pre_gb, post_gb;
  } step_t;
  typedef struct { int gbv; int scorev; } gb_t;
  step_t stepq[$];
  gb_t   gbq[$];

  function automatic void model_reset();
    for (int i = 0; i < SLOTS; i++) m_track[i] = 0;
    m_score = 0; m_gb = 0; m_hold = 0; m_cnt = 0; m_done = 1'b0;
  endfunction

  function automatic logic [77:0] pack_track();
    logic [77:0] r;
    r = '0;
    for (int i = 0; i < SLOTS; i++) r[3*i +: 3] = 3'(m_track[i]);
    return r;
  endfunction

  // One DUT cycle worth of events: an optional frame tick and an optional press.
  function automatic void model_cycle(input bit tick, input int press_v, input int unsigned fall_cyc,
                                      input bit en_v, input bit valid_v, input int code_v);
    step_t e;
    int old_gb;
    bit good, bad, stepped;
    old_gb = m_gb; good = 0; bad = 0; stepped = 0;
    e.cyc = fall_cyc + 3;
    e.pre_ai = pack_track(); e.pre_score = m_score; e.pre_gb = m_gb;
    if (tick && m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_gb = 0;
    end
    if (press_v != 0 && !m_done) begin
      m_done = 1'b1;
      if (m_track[0] != 0 && press_v == (1 << (m_track[0] - 1))) begin
        good = 1; m_track[0] = 0;
        m_score = (m_score < 65535) ? m_score + 1 : 65535;
      end else bad = 1;
    end
    if (tick && en_v) begin
      m_cnt++;
      if (m_cnt == FPS) begin
        m_cnt = 0; stepped = 1;
        if (m_track[0] != 0) bad = 1;
        for (int i = 0; i < SLOTS - 1; i++) m_track[i] = m_track[i+1];
        m_track[SLOTS-1] = (valid_v && code_v <= 4) ? code_v : 0;
        m_done = 1'b0;
      end
    end
    if (bad) begin m_gb = 2; m_hold = HOLD; end
    else if (good) begin m_gb = 1; m_hold = HOLD; end
    if (stepped) begin
      e.post_ai = pack_track(); e.post_score = m_score; e.post_gb = m_gb;
      stepq.push_back(e);
    end
    if (m_gb != old_gb) gbq.push_back('{m_gb, m_score});
  endfunction

  function automatic logic [3:0] pick_btn();
    if (m_track[0] >= 1 && m_track[0] <= 4 && $urandom_range(0, 1) == 1)
      return 4'(1 << (m_track[0] - 1));
    return 4'($urandom_range(1, 15));
  endfunction

  // ---------------- stimulus ----------------
  task automatic frame(input bit collide, input logic [3:0] pb);
    int unsigned fc;
    @(posedge clk); #1;
    vs = 1'b0; fc = cyc;
    model_cycle(1'b1, collide ? int'(pb) : 0, fc, en, code_valid, int'(code));
    @(posedge clk); #1;
    if (collide) btn = pb;
    repeat (3) @(posedge clk);
    #1; vs = 1'b1;
    if (collide) btn = 4'b0;
    repeat (9) @(posedge clk);
  endtask

  task automatic press(input logic [3:0] b, input bit through_frame);
    @(posedge clk); #1;
    btn = b;
    model_cycle(1'b0, int'(b), 0, en, code_valid, int'(code));
    repeat (4) @(posedge clk);
    if (through_frame) frame(1'b0, 4'b0);
    @(posedge clk); #1;
    btn = 4'b0;
    repeat (5) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [1:0] last_gb;
    step_t pend;
    gb_t g;
    int pend_cnt;
    last_gb = 2'b00; pend_cnt = 0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        last_gb = gb; pend_cnt = 0;
        continue;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          chk("post_step_track", ai, pend.post_ai);
          chk("post_step_score", 78'(score), 78'(pend.post_score));
          chk("post_step_good_bad", 78'(gb), 78'(pend.post_gb));
        end
      end
      if (step_pulse) begin
        if (stepq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_step: step_pulse at cycle %0d with no step predicted", cyc);
        end else begin
          pend = stepq.pop_front();
          chk("step_cycle", 78'(cyc), 78'(pend.cyc));
          chk("step_ready", 78'(ready), 78'(1));
          chk("pre_step_track", ai, pend.pre_ai);
          chk("pre_step_score", 78'(score), 78'(pend.pre_score));
          chk("pre_step_good_bad", 78'(gb), 78'(pend.pre_gb));
          pend_cnt = 2;
        end
      end
      if (gb != last_gb) begin
        if (gbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_good_bad: changed to %0d at cycle %0d", gb, cyc);
        end else begin
          g = gbq.pop_front();
          chk("good_bad_change", 78'(gb), 78'(g.gbv));
          chk("good_bad_score", 78'(score), 78'(g.scorev));
        end
        last_gb = gb;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    #1; in_reset = 1'b0;
    chk("reset_track", ai, 78'(0));
    chk("reset_good_bad", 78'(gb), 78'(0));
    chk("reset_score", 78'(score), 78'(0));
    chk("reset_step_pulse", 78'(step_pulse), 78'(0));
    chk("reset_ready", 78'(ready), 78'(0));

    en = 1'b1; code_valid = 1'b1;
    code = 3'b001; repeat (FPS) frame(1'b0, 4'b0);
    chk("first_step_slot25", 78'(ai[77:75]), 78'(1));
    code = 3'b011; repeat (FPS) frame(1'b0, 4'b0);
    code = 3'b010; repeat (FPS) frame(1'b0, 4'b0);
    code = 3'b100; repeat (FPS) frame(1'b0, 4'b0);
    code = 3'b001; repeat (FPS) frame(1'b0, 4'b0);
    code = 3'b111; repeat (FPS) frame(1'b0, 4'b0);
    chk("code111_slot25", 78'(ai[77:75]), 78'(0));
    code_valid = 1'b0;
    repeat (21 * FPS) frame(1'b0, 4'b0);
    chk("up_reaches_slot0", 78'(ai[2:0]), 78'(3));

    press(4'b0100, 1'b0);
    chk("up_hit_good_bad", 78'(gb), 78'(1));
    chk("up_hit_score", 78'(score), 78'(1));
    chk("up_hit_slot0_cleared", 78'(ai[2:0]), 78'(0));
    en = 1'b0;
    repeat (HOLD - 1) frame(1'b0, 4'b0);
    chk("hold_before_expiry", 78'(gb), 78'(1));
    frame(1'b0, 4'b0);
    chk("hold_expired", 78'(gb), 78'(0));

    en = 1'b1;
    repeat (FPS) frame(1'b0, 4'b0);
    chk("down_slot0", 78'(ai[2:0]), 78'(2));
    press(4'b0011, 1'b0);
    press(4'b0010, 1'b0);
    chk("multi_press_bad", 78'(gb), 78'(2));
    chk("second_press_ignored_score", 78'(score), 78'(1));
    repeat (FPS) frame(1'b0, 4'b0);
    chk("right_slot0", 78'(ai[2:0]), 78'(4));
    repeat (FPS) frame(1'b0, 4'b0);
    chk("right_missed_bad", 78'(gb), 78'(2));
    chk("left_moves_to_slot0", 78'(ai[2:0]), 78'(1));
    repeat (FPS - 1) frame(1'b0, 4'b0);
    frame(1'b1, 4'b0001);
    chk("collide_good", 78'(gb), 78'(1));
    chk("collide_score", 78'(score), 78'(2));

    @(posedge clk); #3;
    in_reset = 1'b1; rst_n = 1'b0;
    #1;
    chk("async_reset_track", ai, 78'(0));
    chk("async_reset_good_bad", 78'(gb), 78'(0));
    chk("async_reset_score", 78'(score), 78'(0));
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    #1; in_reset = 1'b0;

    for (int n = 0; n < 700; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      en = ($urandom_range(0, 4) != 0);
      code_valid = 1'($urandom_range(0, 1));
      code = 3'($urandom_range(0, 7));
      if (r < 6)       frame(1'b0, 4'b0);
      else if (r < 8)  press(pick_btn(), 1'b0);
      else if (r == 8) frame(1'b1, pick_btn());
      else             press(pick_btn(), 1'b1);
    end

    repeat (10) @(posedge clk);
    chk("steps_all_seen", 78'(stepq.size()), 78'(0));
    chk("good_bad_changes_all_seen", 78'(gbq.size()), 78'(0));
    chk("final_score", 78'(score), 78'(m_score));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
